// File: rtl/player_pkg.sv
// Shared types and constants for the player ship draw sequencer.
package player_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        UPDATE = 2'd2,
        DRAW   = 2'd3
    } draw_state_e;

    localparam int         SPRITE_W     = 2;
    localparam int         SPRITE_H     = 4;
    localparam logic [7:0] SCREEN_H     = 8'd120;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    // Column of a sprite pixel given its scan offset (add_x is the offset LSB).
    function automatic logic [7:0] pix_col(input logic [7:0] base, input logic [2:0] ofs);
        return base + {7'd0, ofs[0]};
    endfunction

    // Row of a sprite pixel given its scan offset (add_y is the offset MSBs).
    function automatic logic [7:0] pix_row(input logic [7:0] base, input logic [2:0] ofs);
        return base + {6'd0, ofs[2:1]};
    endfunction

endpackage

// File: rtl/sprite_scan.sv
// 2x4 sprite scan offset counter: add_y outer (0..3), add_x inner (0..1).
// Advances only on an accepted pixel; clear has priority.
module sprite_scan
    import player_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       advance,
    output logic       add_x,
    output logic [1:0] add_y,
    output logic       last
);

    logic [2:0] offset_r;

    // Offset register: clear dominates, otherwise step on each accepted pixel.
    always_ff @(posedge clk) begin
        if (clear) begin
            offset_r <= 3'd0;
        end else if (advance) begin
            offset_r <= offset_r + 3'd1;
        end else begin
            offset_r <= offset_r;
        end
    end

    assign add_x = offset_r[0];
    assign add_y = offset_r[2:1];
    assign last  = (offset_r == 3'd7);

endmodule

// File: rtl/player_draw_ctrl.sv
// Player ship draw sequencer. Each accepted frame tick erases the ship at its
// old row (if one is on screen), applies the latched move, then redraws it.
// Pixels leave one per valid/ready handshake; all outputs are registered.
// Build option: SHIP_WRAP_EN makes row moves wrap at 0 / Y_MAX instead of
// saturating.
module player_draw_ctrl
    import player_pkg::*;
#(
    parameter logic [7:0] X_POS   = 8'd155,
    parameter logic [7:0] Y_RESET = 8'd0,
    parameter logic [7:0] Y_MAX   = 8'd116,
    parameter logic [2:0] COLOUR  = 3'b111
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       move_pos,
    input  logic       move_neg,
    output logic       plot_valid,
    input  logic       plot_ready,
    output logic [7:0] x_out,
    output logic [7:0] y_out,
    output logic [2:0] colour_out,
    output logic [7:0] ship_y,
    output logic       busy,
    output logic       overrun
);

    draw_state_e state_r;
    logic        drawn_r;
    logic        mv_pos_r;
    logic        mv_neg_r;

    logic        add_x_s;
    logic [1:0]  add_y_s;
    logic        last_s;
    logic        xfer_s;
    logic        scan_clear_s;
    logic [2:0]  nxt_ofs_s;
    logic [7:0]  new_y_s;

    assign xfer_s       = plot_valid & plot_ready;
    assign scan_clear_s = reset_n | (state_r == IDLE) | (state_r == UPDATE);
    assign nxt_ofs_s    = {add_y_s, add_x_s} + 3'd1;

    sprite_scan u_scan (
        .clk     (clk),
        .clear   (scan_clear_s),
        .advance (xfer_s),
        .add_x   (add_x_s),
        .add_y   (add_y_s),
        .last    (last_s)
    );

    // Next committed row from the move request latched on the accepted tick.
    always_comb begin
        new_y_s = ship_y;
        if (mv_pos_r && !mv_neg_r) begin
            if (ship_y >= Y_MAX) begin
`ifdef SHIP_WRAP_EN
                new_y_s = 8'd0;
`else
                new_y_s = Y_MAX;
`endif
            end else begin
                new_y_s = ship_y + 8'd1;
            end
        end else if (!mv_pos_r && mv_neg_r) begin
            if (ship_y == 8'd0) begin
`ifdef SHIP_WRAP_EN
                new_y_s = Y_MAX;
`else
                new_y_s = 8'd0;
`endif
            end else begin
                new_y_s = ship_y - 8'd1;
            end
        end else begin
            new_y_s = ship_y;
        end
    end

    // Sequencer FSM with registered pixel port, row, busy and overrun flags.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_r    <= IDLE;
            drawn_r    <= 1'b0;
            mv_pos_r   <= 1'b0;
            mv_neg_r   <= 1'b0;
            plot_valid <= 1'b0;
            x_out      <= 8'd0;
            y_out      <= 8'd0;
            colour_out <= 3'd0;
            ship_y     <= Y_RESET;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // A tick that lands while a sequence is running is dropped.
            if (frame_tick && (state_r != IDLE)) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end

            case (state_r)
                IDLE: begin
                    if (frame_tick) begin
                        mv_pos_r <= move_pos;
                        mv_neg_r <= move_neg;
                        busy     <= 1'b1;
                        if (drawn_r) begin
                            state_r    <= ERASE;
                            plot_valid <= 1'b1;
                            x_out      <= X_POS;
                            y_out      <= ship_y;
                            colour_out <= COLOUR_BLACK;
                        end else begin
                            state_r <= UPDATE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end

                ERASE: begin
                    if (xfer_s) begin
                        if (last_s) begin
                            state_r    <= UPDATE;
                            plot_valid <= 1'b0;
                        end else begin
                            x_out <= pix_col(X_POS, nxt_ofs_s);
                            y_out <= pix_row(ship_y, nxt_ofs_s);
                        end
                    end else begin
                        state_r <= ERASE;
                    end
                end

                UPDATE: begin
                    ship_y     <= new_y_s;
                    state_r    <= DRAW;
                    plot_valid <= 1'b1;
                    x_out      <= X_POS;
                    y_out      <= new_y_s;
                    colour_out <= COLOUR;
                end

                DRAW: begin
                    if (xfer_s) begin
                        if (last_s) begin
                            state_r    <= IDLE;
                            plot_valid <= 1'b0;
                            busy       <= 1'b0;
                            drawn_r    <= 1'b1;
                        end else begin
                            x_out <= pix_col(X_POS, nxt_ofs_s);
                            y_out <= pix_row(ship_y, nxt_ofs_s);
                        end
                    end else begin
                        state_r <= DRAW;
                    end
                end

                default: begin
                    state_r    <= IDLE;
                    plot_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_draw_ctrl.sv
// Directed bench for player_draw_ctrl: frame sequences, saturation/wrap,
// back-pressure, overrun and mid-sequence reset.
module tb_player_draw_ctrl;

`ifdef SHIP_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic       move_pos = 1'b0;
    logic       move_neg = 1'b0;
    logic       plot_valid;
    logic       plot_ready = 1'b1;
    logic [7:0] x_out;
    logic [7:0] y_out;
    logic [2:0] colour_out;
    logic [7:0] ship_y;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    player_draw_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .move_pos   (move_pos),
        .move_neg   (move_neg),
        .plot_valid (plot_valid),
        .plot_ready (plot_ready),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .ship_y     (ship_y),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one frame and checks every presented pixel against the expected
    // erase-then-draw sequence, the pixel count, the idle latency and the row.
    task automatic run_frame(input logic pos, input logic neg, input bit exp_erase,
                             input logic [7:0] y_old, input logic [7:0] y_new,
                             input int exp_idle, input bit do_stall, input int tick_at,
                             input string tag);
        int         px;
        int         idle_n;
        int         stall_left;
        int         ph;
        int         n_erase;
        bit         stalled;
        logic [7:0] ex;
        logic [7:0] ey;
        logic [2:0] ec;
        n_erase    = exp_erase ? 8 : 0;
        px         = 0;
        idle_n     = 0;
        stall_left = 0;
        stalled    = 1'b0;
        @(posedge clk); #1;
        frame_tick = 1'b1; move_pos = pos; move_neg = neg;
        @(posedge clk); #1;
        frame_tick = 1'b0; move_pos = ~pos; move_neg = ~neg;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (!busy) begin
                idle_n = n;
                break;
            end
            if (plot_valid) begin
                if (px < n_erase) begin
                    ph = px; ey = y_old; ec = 3'd0;
                end else begin
                    ph = px - n_erase; ey = y_new; ec = 3'd7;
                end
                ex = 8'd155 + ((ph % 2 == 1) ? 8'd1 : 8'd0);
                ey = ey + 8'(ph / 2);
                chk({tag, " x"}, {24'd0, x_out}, {24'd0, ex});
                chk({tag, " y"}, {24'd0, y_out}, {24'd0, ey});
                chk({tag, " colour"}, {29'd0, colour_out}, {29'd0, ec});
                if (plot_ready) px++;
            end
            @(posedge clk); #1;
            frame_tick = (n == tick_at);
            if (do_stall && !stalled && px == n_erase + 2) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                plot_ready = 1'b0;
                stall_left--;
            end else begin
                plot_ready = 1'b1;
            end
        end
        frame_tick = 1'b0;
        plot_ready = 1'b1;
        chk({tag, " pixels"}, px, n_erase + 8);
        chk({tag, " idle latency"}, idle_n, exp_idle);
        chk({tag, " ship_y"}, {24'd0, ship_y}, {24'd0, y_new});
    endtask

    logic [7:0] y_cur;
    int         px_r;
    bit         hit;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst plot_valid", {31'd0, plot_valid}, 32'd0);
        chk("rst x_out", {24'd0, x_out}, 32'd0);
        chk("rst y_out", {24'd0, y_out}, 32'd0);
        chk("rst colour", {29'd0, colour_out}, 32'd0);
        chk("rst ship_y", {24'd0, ship_y}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;

        // First frame: draw only, 10-cycle latency
        run_frame(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 10, 1'b0, 0, "first");
        // Move +1: erase rows 0..3, draw rows 1..4
        run_frame(1'b1, 1'b0, 1'b1, 8'd0, 8'd1, 18, 1'b0, 0, "pos");
        // Move -1 with 5-cycle back-pressure mid-draw
        run_frame(1'b0, 1'b1, 1'b1, 8'd1, 8'd0, 23, 1'b1, 0, "neg_stall");
        // -1 at row 0
        y_cur = WRAP ? 8'd116 : 8'd0;
        run_frame(1'b0, 1'b1, 1'b1, 8'd0, y_cur, 18, 1'b0, 0, "neg_at_0");
        // Climb to the bottom limit
        while (y_cur < 8'd116) begin
            run_frame(1'b1, 1'b0, 1'b1, y_cur, y_cur + 8'd1, 18, 1'b0, 0, "climb");
            y_cur = y_cur + 8'd1;
        end
        // +1 at Y_MAX
        run_frame(1'b1, 1'b0, 1'b1, 8'd116, WRAP ? 8'd0 : 8'd116, 18, 1'b0, 0, "pos_at_max");
        y_cur = WRAP ? 8'd0 : 8'd116;
        chk("overrun idle", {31'd0, overrun}, 32'd0);

        // Tick during ERASE with both moves: dropped, overrun set, row kept
        run_frame(1'b1, 1'b1, 1'b1, y_cur, y_cur, 18, 1'b0, 3, "tick_in_erase");
        chk("overrun set", {31'd0, overrun}, 32'd1);

        // Reset while the 4th draw pixel is presented
        @(posedge clk); #1;
        frame_tick = 1'b1; move_pos = 1'b0; move_neg = 1'b0;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        px_r = 0;
        hit  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (plot_valid && plot_ready) px_r++;
            if (px_r == 11) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach 4th draw", {31'd0, hit}, 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst plot_valid", {31'd0, plot_valid}, 32'd0);
        chk("midrst ship_y", {24'd0, ship_y}, 32'd0);
        chk("midrst overrun", {31'd0, overrun}, 32'd0);
        chk("midrst busy", {31'd0, busy}, 32'd0);

        // Next tick draws without erasing
        run_frame(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 10, 1'b0, 0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
